// File: rtl/demux_rr_n.sv
// demux_rr_n: round-robin N-way demultiplexer for a valid/ready byte stream.
// Channel switch happens at burst end (MODE 0, optionally capped by MAX_BURST) or after every word (MODE 1).
module demux_rr_n #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int MODE       = 0,
   parameter int MAX_BURST  = 0
) (
   input  logic                           clk2f,
   input  logic                           reset,
   input  logic [DATA_WIDTH-1:0]          data_in_c,
   input  logic                           valid_in_c,
   output logic                           ready_out_c,
   output logic [NUM_CH*DATA_WIDTH-1:0]   data_out_c,
   output logic [NUM_CH-1:0]              valid_out_c,
   input  logic [NUM_CH-1:0]              ready_in_c,
   output logic [$clog2(NUM_CH)-1:0]      active_ch
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, TRANS, GAP} state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_d, ch_plus;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
   logic              accept;
   logic              start_burst, cont_burst, end_burst;
   logic [NUM_CH-1:0] wr_sel;

   assign ready_out_c = !valid_out_c[active_ch] || ready_in_c[active_ch];
   assign accept      = valid_in_c && ready_out_c;
   assign ch_plus     = (active_ch == LAST_CH) ? '0 : active_ch + 1'b1;

   always_comb begin
      wr_sel = '0;
      wr_sel[active_ch] = accept;
   end

   // Output slots: a load wins over a drain so a slot can be emptied and refilled in one cycle.
   always_ff @(posedge clk2f or posedge reset) begin
      if (reset) begin
         data_out_c  <= '0;
         valid_out_c <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_sel[k]) begin
               data_out_c[k*DATA_WIDTH +: DATA_WIDTH] <= data_in_c;
               valid_out_c[k] <= 1'b1;
            end else if (valid_out_c[k] && ready_in_c[k]) begin
               valid_out_c[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk2f or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         active_ch <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         active_ch <= ch_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = active_ch;
      cnt_d       = cnt_q;
      start_burst = 1'b0;
      cont_burst  = 1'b0;
      end_burst   = 1'b0;
      cnt_base    = '0;

      case (state_q)
         IDLE, GAP: begin
            if (accept) begin
               state_d     = TRANS;
               start_burst = 1'b1;
            end
         end
         TRANS: begin
            if (accept) begin
               cont_burst = 1'b1;
            end else if (!valid_in_c) begin
               state_d   = GAP;
               end_burst = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A zero counter at burst end means the length cap already advanced the channel.
      if (MODE == 1) begin
         if (accept) ch_d = ch_plus;
      end else if (start_burst || cont_burst) begin
         cnt_base = start_burst ? '0 : cnt_q;
         if (MAX_BURST != 0 && (int'(cnt_base) + 1) == MAX_BURST) begin
            ch_d  = ch_plus;
            cnt_d = '0;
         end else begin
            cnt_d = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
         end
      end else if (end_burst) begin
         if (cnt_q != '0) ch_d = ch_plus;
         cnt_d = '0;
      end
   end

endmodule

// File: doc/demux_rr_n.md
Name: demux_rr_n

Overview:
- Parametrised N-way successor to the 2-way burst-alternating demultiplexer in the lane-split path.
- Routes a single valid-qualified byte stream to NUM_CH output channels in round-robin order.
- Switch point is either the end of a burst or every accepted word, set by MODE.
- Adds per-channel backpressure, registered outputs and an optional maximum burst length.

Parameters:
DATA_WIDTH, 8, width of data words.
NUM_CH, 4, number of output channels (2..16).
MODE, 0, 0 = switch channel at end of burst; 1 = switch after every accepted word.
MAX_BURST, 0, maximum words per burst before a forced switch (MODE 0 only); 0 = unlimited.

Ports:
clk2f  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
data_in_c  input  DATA_WIDTH  upstream data.
valid_in_c  input  1  upstream word valid.
ready_out_c  output  1  upstream may present a word; combinational.
data_out_c  output  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; registered.
valid_out_c  output  NUM_CH  per-channel valid; registered.
ready_in_c  input  NUM_CH  per-channel downstream ready.
active_ch  output  clog2(NUM_CH)  channel that will receive the next accepted word.

Behaviour:
- Reset (asynchronous, while reset=1): data_out_c=0, valid_out_c=0, active_ch=0, burst counter=0, FSM=IDLE. Words held in output registers are dropped.
- ready_out_c = !valid_out_c[active_ch] || ready_in_c[active_ch]. Only the selected channel's slot matters; a full non-selected channel never stalls the input.
- accept = valid_in_c && ready_out_c.
- On accept: data_out_c[active_ch] <= data_in_c and valid_out_c[active_ch] <= 1. Latency is 1 cycle.
- For each channel k not written in the cycle: if valid_out_c[k] && ready_in_c[k], valid_out_c[k] <= 0. Data holds while valid && !ready.
- A channel written in the same cycle it is drained keeps valid=1 with the new data (simultaneous drain + load).
- next(ch) = ch+1, wrapping NUM_CH-1 -> 0.
- FSM states: IDLE (no word since reset), TRANS (inside a burst), GAP (burst ended, waiting).
- IDLE:
  - On accept -> TRANS; active_ch stays 0; counter <= 1.
  - Otherwise stay.
- TRANS, MODE 0:
  - accept and (counter+1 == MAX_BURST, MAX_BURST != 0): active_ch <= next, counter <= 0, stay TRANS. A forced switch can hand a continuing stream to the next channel.
  - accept otherwise: counter++.
  - valid_in_c=0: burst ends. If counter != 0, active_ch <= next. If counter == 0 (switch already done by the limit), no second advance. Counter <= 0, -> GAP.
  - valid_in_c=1 && !ready_out_c: stall. Not a burst end; counter and active_ch hold.
- GAP:
  - On accept -> TRANS with the same limit check as TRANS; counter <= 1, or forced switch if MAX_BURST==1.
  - Otherwise stay.
- MODE 1: every accept advances active_ch; the counter is unused. FSM goes IDLE->TRANS on first accept, TRANS->GAP on valid_in_c=0, GAP->TRANS on accept; no advance on gaps.
- Counter width: clog2(MAX_BURST+1), minimum 1 bit.
- Reset asserted mid-burst or mid-stall: immediate return to reset values; the first word after release goes to channel 0.
- When valid_in_c=0, data_in_c is ignored; outputs never change due to it.

Test Plan:
- MODE 0, NUM_CH=4, all ready: bursts 3x{A0,A1,A2} separated by 1 idle cycle -> burst 1 on ch0, 2 on ch1, 3 on ch2; each word appears 1 cycle after input; 5th burst wraps to ch0.
- MODE 0, MAX_BURST=2: continuous valid with words 10..15 -> ch0 {10,11}, ch1 {12,13}, ch2 {14,15}; then valid low -> active_ch=3 with no double advance.
- Backpressure: ch0 ready_in_c=0 while a burst targets ch0 -> first word held on data_out_c[0] with valid=1; ready_out_c=0 from the 2nd word; raising ready resumes with no word loss or duplication.
- MODE 1, NUM_CH=3: words 1..7 back-to-back -> ch0 {1,4,7}, ch1 {2,5}, ch2 {3,6}; an idle cycle does not change active_ch.
- Simultaneous drain + load: ch1 valid and ready_in_c[1]=1 while a new word targets ch1 -> valid_out_c[1] stays 1 with the new data.
- Reset pulse asserted mid-burst (no clock edge) -> all valid_out_c=0 and active_ch=0 immediately; the next burst goes to ch0.
